// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_BIT_T_DEFAULT = 5208;
    localparam int unsigned UART_CLK_HZ        = 50_000_000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..T-1 while enabled and flags the last clock of each bit.
module uart_baud_cnt #(
    parameter int unsigned T = 5208
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [$clog2(T)-1:0]  cnt,
    output logic                  end_pulse
);

    localparam int unsigned CW = $clog2(T);

    assign end_pulse = en && (cnt == CW'(T - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (end_pulse) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART 8N1 transmitter, one byte per valid/ready handshake, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned T = UART_BIT_T_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_vld,
    output logic                   tx_rdy,
    output logic                   tx_uart,
    output logic                   tx_done
);

    localparam int unsigned CW = $clog2(T);
    localparam int unsigned IW = 3;

    uart_state_e            state;
    uart_state_e            state_nxt;
    logic [UART_DATA_W-1:0] data_q;
    logic [UART_DATA_W-1:0] data_nxt;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_nxt;
    logic                   line_c;
    logic                   accept_c;
    logic                   busy_c;
    logic                   bit_end_c;
    logic [CW-1:0]          baud_cnt;

    assign tx_rdy   = (state == IDLE);
    assign accept_c = tx_vld && tx_rdy;
    assign busy_c   = (state != IDLE);
    assign tx_done  = (state == STOP) && (baud_cnt == CW'(T - 1));

    uart_baud_cnt #(
        .T (T)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept_c),
        .en        (busy_c),
        .cnt       (baud_cnt),
        .end_pulse (bit_end_c)
    );

    // Next state, latched byte/bit index, and the line level for the current state
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        idx_nxt   = idx_q;
        line_c    = 1'b1;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    data_nxt  = tx_data;
                    idx_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                line_c = 1'b0;
                if (bit_end_c) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                line_c = data_q[idx_q];
                if (bit_end_c) begin
                    idx_nxt = idx_q + IW'(1);
                    if (idx_q == IW'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_c = ^data_q;
                if (bit_end_c) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                line_c = 1'b1;
                if (bit_end_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line is registered one clock behind the state, so the start bit appears after the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            tx_uart <= 1'b1;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            idx_q   <= idx_nxt;
            tx_uart <= line_c;
        end
    end

endmodule
